// File: rtl/pll_reset_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pll_reset_seq                                                   |
// | Purpose  : Holds system reset until PLL lock is synchronised and stable;   |
// |            records and counts every loss of lock seen in RUN.             |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module pll_reset_seq #(
  parameter int STABLE_CYCLES = 1024,
  parameter int MIN_RESET     = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       locked,
  input  logic       clear_lost,
  output logic       sys_reset,
  output logic       ready,
  output logic       lock_lost,
  output logic [7:0] lock_loss_count
);

  localparam int c_MAX_CYCLES = (STABLE_CYCLES > MIN_RESET) ? STABLE_CYCLES : MIN_RESET;
  localparam int c_CNT_W      = (c_MAX_CYCLES > 2) ? $clog2(c_MAX_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_HOLD_LAST = c_CNT_W'(MIN_RESET - 1);
  localparam logic [c_CNT_W-1:0] c_QUAL_LAST = c_CNT_W'(STABLE_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

  typedef enum logic [1:0] {
    ST_HOLD      = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_QUALIFY   = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  state_t               r_state;
  logic [c_CNT_W-1:0]   r_count;
  logic                 r_sync1;
  logic                 r_locked_s;
  logic                 r_sys_reset;
  logic                 r_ready;
  logic                 r_lock_lost;
  logic [7:0]           r_loss_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_HOLD;
      r_count      <= '0;
      r_sync1      <= 1'b0;
      r_locked_s   <= 1'b0;
      r_sys_reset  <= 1'b1;
      r_ready      <= 1'b0;
      r_lock_lost  <= 1'b0;
      r_loss_count <= 8'd0;
    end else begin
      r_sync1    <= locked;
      r_locked_s <= r_sync1;

      // A loss in RUN below overrides this clear on the same edge.
      if (clear_lost) begin
        r_lock_lost <= 1'b0;
      end

      case (r_state)
        ST_HOLD: begin
          if (r_count == c_HOLD_LAST) begin
            r_state <= ST_WAIT_LOCK;
          end else begin
            r_count <= r_count + c_CNT_ONE;
          end
        end
        ST_WAIT_LOCK: begin
          if (r_locked_s) begin
            r_state <= ST_QUALIFY;
            r_count <= '0;
          end
        end
        ST_QUALIFY: begin
          if (!r_locked_s) begin
            r_state <= ST_WAIT_LOCK;
          end else if (r_count == c_QUAL_LAST) begin
            r_state     <= ST_RUN;
            r_sys_reset <= 1'b0;
            r_ready     <= 1'b1;
          end else begin
            r_count <= r_count + c_CNT_ONE;
          end
        end
        ST_RUN: begin
          if (!r_locked_s) begin
            r_state     <= ST_HOLD;
            r_count     <= '0;
            r_sys_reset <= 1'b1;
            r_ready     <= 1'b0;
            r_lock_lost <= 1'b1;
            if (r_loss_count != 8'hFF) begin
              r_loss_count <= r_loss_count + 8'd1;
            end
          end
        end
        default: begin
          r_state     <= ST_HOLD;
          r_count     <= '0;
          r_sys_reset <= 1'b1;
          r_ready     <= 1'b0;
        end
      endcase
    end
  end

  assign sys_reset       = r_sys_reset;
  assign ready           = r_ready;
  assign lock_lost       = r_lock_lost;
  assign lock_loss_count = r_loss_count;

endmodule
`default_nettype wire

// File: tb/tb_pll_reset_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_pll_reset_seq                                                |
// | Purpose  : Scoreboard bench for pll_reset_seq (STABLE_CYCLES=8, MIN_RESET=4)|
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_pll_reset_seq;

  logic       clock;
  logic       reset;
  logic       locked;
  logic       clear_lost;
  logic       sys_reset;
  logic       ready;
  logic       lock_lost;
  logic [7:0] lock_loss_count;

  typedef struct packed {
    logic       sr;
    logic       rdy;
    logic       lost;
    logic [7:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   vectors;
  int   miscompares;

  pll_reset_seq #(
    .STABLE_CYCLES(8),
    .MIN_RESET    (4)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .locked         (locked),
    .clear_lost     (clear_lost),
    .sys_reset      (sys_reset),
    .ready          (ready),
    .lock_lost      (lock_lost),
    .lock_loss_count(lock_loss_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic exp_t mk(input logic sr, input logic rdy, input logic lost, input logic [7:0] cnt);
    exp_t r;
    r.sr   = sr;
    r.rdy  = rdy;
    r.lost = lost;
    r.cnt  = cnt;
    return r;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    exp_t e, got;
    reset = 1'b1; locked = 1'b0; clear_lost = 1'b0;
    for (int i = 0; i < 23; i++) begin
      if (i == 3) reset = 1'b0;
      exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 8'd0));
      tick();
      e = exp_q.pop_front();
      got = mk(sys_reset, ready, lock_lost, lock_loss_count);
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL power_up cyc%0d: got sr/rdy/lost/cnt=%b/%b/%b/%0d expected %b/%b/%b/%0d",
                 i, got.sr, got.rdy, got.lost, got.cnt, e.sr, e.rdy, e.lost, e.cnt);
      end
    end
  endtask

  task automatic test_acquire();
    exp_t e, got;
    locked = 1'b1;
    for (int i = 0; i < 12; i++) begin
      exp_q.push_back(mk(i < 10, i >= 10, 1'b0, 8'd0));
      tick();
      e = exp_q.pop_front();
      got = mk(sys_reset, ready, lock_lost, lock_loss_count);
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL acquire E%0d: got sr/rdy/lost/cnt=%b/%b/%b/%0d expected %b/%b/%b/%0d",
                 i, got.sr, got.rdy, got.lost, got.cnt, e.sr, e.rdy, e.lost, e.cnt);
      end
    end
  endtask

  task automatic test_qualify_abort();
    exp_t e, got;
    reset = 1'b1; locked = 1'b0;
    tick();
    reset = 1'b0;
    repeat (8) tick();
    // Dip at E5; re-rise first sampled at E6, so release lands at E16.
    for (int i = 0; i < 18; i++) begin
      locked = (i == 5) ? 1'b0 : 1'b1;
      exp_q.push_back(mk(i < 16, i >= 16, 1'b0, 8'd0));
      tick();
      e = exp_q.pop_front();
      got = mk(sys_reset, ready, lock_lost, lock_loss_count);
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL qualify_abort E%0d: got sr/rdy/lost/cnt=%b/%b/%b/%0d expected %b/%b/%b/%0d",
                 i, got.sr, got.rdy, got.lost, got.cnt, e.sr, e.rdy, e.lost, e.cnt);
      end
    end
  endtask

  task automatic test_loss_in_run();
    exp_t e, got;
    for (int i = 0; i < 17; i++) begin
      locked = (i == 0) ? 1'b0 : 1'b1;
      if (i < 2)       exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 8'd0));
      else if (i < 15) exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 8'd1));
      else             exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 8'd1));
      tick();
      e = exp_q.pop_front();
      got = mk(sys_reset, ready, lock_lost, lock_loss_count);
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL loss_in_run E%0d: got sr/rdy/lost/cnt=%b/%b/%b/%0d expected %b/%b/%b/%0d",
                 i, got.sr, got.rdy, got.lost, got.cnt, e.sr, e.rdy, e.lost, e.cnt);
      end
    end
  endtask

  task automatic test_flag_counter();
    exp_t e, got;
    int   waited;
    for (int i = 0; i < 19; i++) begin
      locked     = (i == 0) ? 1'b0 : 1'b1;
      clear_lost = (i == 2 || i == 17) ? 1'b1 : 1'b0;
      if (i < 2)       exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 8'd1));
      else if (i < 15) exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 8'd2));
      else if (i < 17) exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 8'd2));
      else             exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 8'd2));
      tick();
      e = exp_q.pop_front();
      got = mk(sys_reset, ready, lock_lost, lock_loss_count);
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL flag_clear E%0d: got sr/rdy/lost/cnt=%b/%b/%b/%0d expected %b/%b/%b/%0d",
                 i, got.sr, got.rdy, got.lost, got.cnt, e.sr, e.rdy, e.lost, e.cnt);
      end
    end
    clear_lost = 1'b0;
    for (int n = 3; n <= 300; n++) begin
      exp_q.push_back(mk(1'b1, 1'b0, 1'b1, (n > 255) ? 8'd255 : 8'(n)));
      locked = 1'b0;
      tick();
      locked = 1'b1;
      tick();
      tick();
      e = exp_q.pop_front();
      got = mk(sys_reset, ready, lock_lost, lock_loss_count);
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL saturate loss%0d: got sr/rdy/lost/cnt=%b/%b/%b/%0d expected %b/%b/%b/%0d",
                 n, got.sr, got.rdy, got.lost, got.cnt, e.sr, e.rdy, e.lost, e.cnt);
      end
      waited = 0;
      while (ready !== 1'b1 && waited < 40) begin
        tick();
        waited++;
      end
      if (ready !== 1'b1) begin
        vectors++;
        miscompares++;
        $display("FAIL reacquire_timeout loss%0d: ready=%b after %0d cycles, expected 1", n, ready, waited);
        break;
      end
    end
  endtask

  task automatic test_reset_in_run();
    exp_t e, got;
    for (int i = 0; i < 15; i++) begin
      reset = (i == 0) ? 1'b1 : 1'b0;
      // Reset edge, HOLD for 4 edges, WAIT_LOCK, then 8 qualify edges: RUN at edge 13.
      exp_q.push_back(mk(i < 13, i >= 13, 1'b0, 8'd0));
      tick();
      e = exp_q.pop_front();
      got = mk(sys_reset, ready, lock_lost, lock_loss_count);
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL reset_in_run cyc%0d: got sr/rdy/lost/cnt=%b/%b/%b/%0d expected %b/%b/%b/%0d",
                 i, got.sr, got.rdy, got.lost, got.cnt, e.sr, e.rdy, e.lost, e.cnt);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    locked      = 1'b0;
    clear_lost  = 1'b0;
    #1;
    test_reset();
    test_acquire();
    test_qualify_abort();
    test_loss_in_run();
    test_flag_counter();
    test_reset_in_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/pll_reset_seq.md
# pll_reset_seq

Reset sequencer for the PLL lock output. It runs on the board reference oscillator, synchronises the asynchronous `locked` signal, and holds the system reset until the lock has been stable for a qualified interval. Any loss of lock is recorded and the system is forced back into reset. It sits between the iCE40 PLL wrapper and the video/CPU core reset inputs; downstream logic re-synchronises `sys_reset` into the PLL output domain.

## Interface
- `STABLE_CYCLES`, 1024: consecutive synchronised-locked cycles required before reset release (≥2).
- `MIN_RESET`, 16: minimum number of cycles spent in HOLD with `sys_reset` asserted (≥1).
- `clock`  in  1: reference oscillator clock (16 MHz); the only clock.
- `reset`  in  1: synchronous, active-high.
- `locked`  in  1: PLL lock, asynchronous to `clock`.
- `clear_lost`  in  1: one-cycle pulse, clears `lock_lost`.
- `sys_reset`  out  1: active-high system reset; high in every state except RUN.
- `ready`  out  1: high only in RUN.
- `lock_lost`  out  1: sticky; set on every RUN→HOLD transition.
- `lock_loss_count`  out  8: number of lock losses, saturating at 255.

## Operation
- Two-flop synchroniser: `locked` → `sync1` → `locked_s`. Both flops clear to 0 on reset. Only `locked_s` is used by the FSM.
- States: HOLD, WAIT_LOCK, QUALIFY, RUN. One cycle counter, wide enough for max(STABLE_CYCLES, MIN_RESET).
- **HOLD** is entered on reset or on lock loss, with counter = 0.
  - `locked_s` is ignored.
  - Counter increments each cycle.
  - When counter = MIN_RESET−1: go to WAIT_LOCK.
- **WAIT_LOCK**: if `locked_s` = 1, go to QUALIFY with counter = 0.
- **QUALIFY**:
  - If `locked_s` = 0: go to WAIT_LOCK. No loss is counted.
  - Else if counter = STABLE_CYCLES−1: go to RUN.
  - Else: counter increments.
- **RUN**: if `locked_s` = 0, go to HOLD with counter = 0, set `lock_lost`, and increment `lock_loss_count` (hold at 255 once reached).
- Outputs are decoded from the state register only (Moore, glitch-free):
  - `sys_reset` = (state ≠ RUN)
  - `ready` = (state = RUN)
- `clear_lost` clears `lock_lost` on the next edge. If a set and a clear occur on the same edge, the set wins. `lock_loss_count` is cleared only by `reset`.
- Reset values:
  - state = HOLD, counter = 0
  - `sys_reset` = 1, `ready` = 0
  - `lock_lost` = 0, `lock_loss_count` = 0
  - synchroniser flops = 0
- Reset asserted mid-operation (any state) returns to HOLD on the same edge with all registers at their reset values. `clear_lost` and `locked` are ignored while `reset` = 1.

## Timing
- Synchroniser latency is 2 edges: `locked` sampled at edge E0 is visible as `locked_s` after E1.
- **Lock acquire** (WAIT_LOCK, `locked` first sampled high at E0 and held):
  - QUALIFY entered at E2.
  - RUN entered at E(STABLE_CYCLES+2).
  - `sys_reset` falls and `ready` rises after that edge.
- **Lock loss in RUN** (`locked` first sampled low at E0):
  - HOLD entered at E2.
  - `sys_reset` rises, `ready` falls, and `lock_lost`/`lock_loss_count` update, all at E2.
- **Minimum reset pulse**: `sys_reset` stays high for at least MIN_RESET + 1 + STABLE_CYCLES cycles per episode (HOLD + WAIT_LOCK + QUALIFY), even if `locked` never drops.
- A `locked` glitch shorter than one clock period may be missed entirely. This is acceptable; the PLL holds LOCK low for many reference cycles.

## Test plan
Scenarios 1–5 use STABLE_CYCLES = 8 and MIN_RESET = 4.

1. **Power-up**: `reset` high for 3 cycles, then low, with `locked` = 0 throughout → `sys_reset` = 1, `ready` = 0, count = 0; FSM reaches WAIT_LOCK 4 cycles after `reset` falls and stays there.
2. **Acquire**: `locked` raised at E0 with the FSM in WAIT_LOCK → `sys_reset` falls and `ready` rises after E10; `lock_lost` = 0.
3. **Qualify abort**: `locked` high for 5 cycles, low for 1, then high → no release at the original E10 point; release occurs 10 edges after the re-rise is first sampled; `lock_loss_count` stays 0.
4. **Loss in RUN**: drop `locked` for 1 cycle → `sys_reset` rises at E2; `lock_lost` = 1, count = 1; HOLD lasts 4 cycles, then the full re-acquire sequence runs.
5. **Flag and counter**: pulse `clear_lost` on the same edge as a second loss → `lock_lost` stays 1 and count = 2. A later `clear_lost` alone → `lock_lost` = 0 and count stays 2. Force 300 losses → count saturates at 255.
6. **Reset in RUN**: assert `reset` for 1 cycle while in RUN → next edge gives `sys_reset` = 1, `ready` = 0, count = 0, `lock_lost` = 0, state HOLD.
